// File: rtl/vc_deserializer_pkg.sv
// Shared constants and types for the VC deserializer: VC id width, word width
// and output FIFO geometry, kept in one place so every stage agrees on them.
package vc_deserializer_pkg;

  localparam int NUM_VC     = 4;
  localparam int VC_W       = 2;
  localparam int WORD_W     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = $clog2(WORD_W);
  localparam int ENTRY_W    = VC_W + WORD_W;

  typedef struct packed {
    logic [VC_W-1:0]   vc;
    logic [WORD_W-1:0] word;
  } word_entry_t;

endpackage

// File: rtl/vc_deserializer_if.sv
// Serial-bit input and word-output handshake bundle of the VC deserializer.
interface vc_deserializer_if;
  import vc_deserializer_pkg::*;

  logic              data_in;
  logic [VC_W-1:0]   VC_id;
  logic              bit_valid;
  logic              word_ready;
  logic              word_valid;
  logic [WORD_W-1:0] word_out;
  logic [VC_W-1:0]   word_vc;
  logic [PTR_W:0]    fill_count;
  logic              fifo_full;
  logic              overflow;

  modport master (
    output data_in, VC_id, bit_valid, word_ready,
    input  word_valid, word_out, word_vc, fill_count, fifo_full, overflow
  );

  modport slave (
    input  data_in, VC_id, bit_valid, word_ready,
    output word_valid, word_out, word_vc, fill_count, fifo_full, overflow
  );

endinterface

// File: rtl/vc_deserializer_word_fifo.sv
// Show-ahead synchronous FIFO: the head entry is driven straight from storage
// at the read pointer and forced to zero while empty.
module vc_word_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    full     = (count_q == (PTR_W+1)'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO can still take a push.
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/vc_deserializer.sv
// Rebuilds per-VC words from the granted serial stream and queues completed,
// VC-tagged words for the sink; a word arriving at a full FIFO is dropped and flagged.
module vc_deserializer
  import vc_deserializer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  vc_deserializer_if.slave     bus
);

  logic [WORD_W-1:0] shreg_q [NUM_VC];
  logic [WORD_W-1:0] shreg_d [NUM_VC];
  logic [CNT_W-1:0]  cnt_q   [NUM_VC];
  logic [CNT_W-1:0]  cnt_d   [NUM_VC];
  logic              overflow_q, overflow_d;

  logic              push;
  logic              pop;
  logic [WORD_W-1:0] nxt_word;
  word_entry_t       push_entry;
  word_entry_t       head_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PTR_W:0]    fifo_count;

  assign pop = ~fifo_empty & bus.word_ready;

  always_comb begin
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_entry = '0;
    nxt_word   = {shreg_q[bus.VC_id][WORD_W-2:0], bus.data_in};
    if (bus.bit_valid) begin
      if (cnt_q[bus.VC_id] == CNT_W'(WORD_W-1)) begin
        push                = 1'b1;
        push_entry.vc       = bus.VC_id;
        push_entry.word     = nxt_word;
        shreg_d[bus.VC_id]  = '0;
        cnt_d[bus.VC_id]    = '0;
      end else begin
        shreg_d[bus.VC_id]  = nxt_word;
        cnt_d[bus.VC_id]    = cnt_q[bus.VC_id] + CNT_W'(1);
      end
    end
    // Drop only when no pop frees a slot on this edge; the lane restarts regardless.
    overflow_d = overflow_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        shreg_q[v] <= '0;
        cnt_q[v]   <= '0;
      end
      overflow_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  vc_word_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.word_valid = ~fifo_empty;
  assign bus.word_out   = head_entry.word;
  assign bus.word_vc    = head_entry.vc;
  assign bus.fill_count = fifo_count;
  assign bus.fifo_full  = fifo_full;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_vc_deserializer.sv
// Scoreboard bench: a queue-based reference model predicts every word, and a
// negedge monitor compares each handshake and the status outputs against it.
module tb_vc_deserializer;
  import vc_deserializer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_deserializer_if bus_if ();

  vc_deserializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: per-VC lists of received bits and a bounded word queue.
  int          bits [NUM_VC][$];
  word_entry_t exp_q[$];
  int          occ   = 0;
  bit          m_ovf = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ   = 0;
      m_ovf = 1'b0;
      exp_q.delete();
      for (int v = 0; v < NUM_VC; v++) bits[v].delete();
    end else begin
      bit          pop_m;
      bit          push_m;
      word_entry_t e;
      int          vc;
      pop_m  = bus_if.word_ready && (occ > 0);
      push_m = 1'b0;
      e      = '0;
      vc     = int'(bus_if.VC_id);
      if (bus_if.bit_valid) begin
        bits[vc].push_back(int'(bus_if.data_in));
        if (bits[vc].size() == WORD_W) begin
          int w;
          w = 0;
          for (int i = 0; i < WORD_W; i++) w = w * 2 + bits[vc][i];
          e.vc   = VC_W'(vc);
          e.word = WORD_W'(w);
          bits[vc].delete();
          push_m = 1'b1;
        end
      end
      if (pop_m) occ--;
      if (push_m) begin
        if (occ < FIFO_DEPTH) begin
          exp_q.push_back(e);
          occ++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on handshakes.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_valid", int'(bus_if.word_valid), 0);
      chk("rst_word",  int'(bus_if.word_out),   0);
      chk("rst_fill",  int'(bus_if.fill_count), 0);
      chk("rst_ovf",   int'(bus_if.overflow),   0);
    end else begin
      chk("fill_count", int'(bus_if.fill_count), occ);
      chk("fifo_full",  int'(bus_if.fifo_full),  int'(occ == FIFO_DEPTH));
      chk("word_valid", int'(bus_if.word_valid), int'(occ > 0));
      chk("overflow",   int'(bus_if.overflow),   int'(m_ovf));
      if (occ == 0) begin
        chk("empty_word", int'(bus_if.word_out), 0);
        chk("empty_vc",   int'(bus_if.word_vc),  0);
      end
      if (bus_if.word_valid && bus_if.word_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          word_entry_t e;
          e = exp_q.pop_front();
          chk("word_out", int'(bus_if.word_out), int'(e.word));
          chk("word_vc",  int'(bus_if.word_vc),  int'(e.vc));
        end
      end
    end
  end

  task automatic step(input int vc, input int b, input int v, input int r);
    bus_if.VC_id      = VC_W'(vc);
    bus_if.data_in    = b[0];
    bus_if.bit_valid  = v[0];
    bus_if.word_ready = r[0];
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int vc, input int w, input int r);
    for (int i = WORD_W - 1; i >= 0; i--) step(vc, (w >> i) & 1, 1, r);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("async_valid", int'(bus_if.word_valid), 0);
    chk("async_fill",  int'(bus_if.fill_count), 0);
    chk("async_ovf",   int'(bus_if.overflow),   0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    bus_if.data_in    = 1'b0;
    bus_if.VC_id      = '0;
    bus_if.bit_valid  = 1'b0;
    bus_if.word_ready = 1'b0;
    reset             = 1'b0;
    #1;
    chk("reset_valid", int'(bus_if.word_valid), 0);
    chk("reset_word",  int'(bus_if.word_out),   0);
    chk("reset_vc",    int'(bus_if.word_vc),    0);
    chk("reset_full",  int'(bus_if.fifo_full),  0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single word on VC2.
    send_word(2, 4'b1011, 0);
    chk("t1_valid", int'(bus_if.word_valid), 1);
    chk("t1_word",  int'(bus_if.word_out),   4'b1011);
    chk("t1_vc",    int'(bus_if.word_vc),    2);
    chk("t1_fill",  int'(bus_if.fill_count), 1);
    drain(2);

    // Interleaved VC0/VC1 bits.
    step(0, 1, 1, 1); step(1, 0, 1, 1);
    step(0, 1, 1, 1); step(1, 1, 1, 1);
    step(0, 0, 1, 1); step(1, 0, 1, 1);
    step(0, 0, 1, 1); step(1, 1, 1, 1);
    drain(3);

    // Unqualified bits with toggling data on VC3.
    step(3, 1, 1, 0); step(3, 1, 0, 0);
    step(3, 0, 1, 0); step(3, 0, 0, 0); step(3, 1, 0, 0);
    step(3, 0, 1, 0); step(3, 0, 0, 0); step(3, 1, 1, 0);
    chk("t4_word", int'(bus_if.word_out), 4'b1001);
    chk("t4_vc",   int'(bus_if.word_vc),  3);
    drain(2);

    // Five words into a stalled FIFO: the fifth is dropped.
    for (int k = 0; k < 5; k++) send_word(1, k + 3, 0);
    chk("t3_full", int'(bus_if.fifo_full),  1);
    chk("t3_fill", int'(bus_if.fill_count), 4);
    chk("t3_ovf",  int'(bus_if.overflow),   1);
    drain(6);
    chk("t3_ovf_sticky", int'(bus_if.overflow), 1);

    // Reset mid-word with a queued word pending.
    send_word(2, 4'b0111, 0);
    step(0, 1, 1, 0); step(0, 1, 1, 0);
    #3;
    do_reset();
    send_word(0, 4'b0110, 0);
    chk("t6_word", int'(bus_if.word_out), 4'b0110);
    chk("t6_ovf",  int'(bus_if.overflow), 0);
    drain(2);

    // Full FIFO popped on the edge that completes the fifth word.
    for (int k = 0; k < 4; k++) send_word(k, 4'b1000 | k, 0);
    step(2, 1, 1, 0); step(2, 0, 1, 0); step(2, 1, 1, 0);
    step(2, 0, 1, 1);
    chk("t5_fill", int'(bus_if.fill_count), 4);
    chk("t5_ovf",  int'(bus_if.overflow),   0);
    drain(6);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(int'($urandom_range(NUM_VC - 1)), int'($urandom_range(1)),
           int'($urandom_range(3) != 0), int'($urandom_range(1)));
    end
    drain(8);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
